// File: rtl/noc_client_tx.sv
`timescale 1ns/1ps
// noc_client_tx
// Client-side packet transmitter feeding one pi_switch input port.
// A packet request (dest, len) is accepted in IDLE; the following len payload
// beats are tagged with dest and pushed into a 2-entry skid buffer whose head
// drives the switch-facing stream. Illegal requests are dropped with a
// one-cycle err pulse.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           packet request handshake
//   req_dest [A_W], req_len [LEN_W] request fields
//   pl_data [D_W], pl_valid/pl_ready payload beat stream (pl_ready registered)
//   m_axis_wdata [A_W+D_W]        flit {dest, data} to the switch
//   m_axis_wvalid/m_axis_wready   flit handshake
//   m_axis_wlast                  final flit of a packet
//   busy                          packet in progress or flits buffered
//   err                           one-cycle pulse when a request is dropped
//   pkt_count [32]                packets completed (wlast handshakes), wrapping
module noc_client_tx #(
  parameter int N       = 2,
  parameter int A_W     = $clog2(N) + 1,
  parameter int D_W     = 32,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [A_W-1:0]       req_dest,
  input  logic [LEN_W-1:0]     req_len,
  input  logic [D_W-1:0]       pl_data,
  input  logic                 pl_valid,
  output logic                 pl_ready,
  output logic [A_W+D_W-1:0]   m_axis_wdata,
  output logic                 m_axis_wvalid,
  input  logic                 m_axis_wready,
  output logic                 m_axis_wlast,
  output logic                 busy,
  output logic                 err,
  output logic [31:0]          pkt_count
);

  localparam logic [31:0] MAX_LEN_U = 32'(MAX_LEN);
  localparam logic [31:0] N_U       = 32'(N);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_nxt;
  logic [A_W-1:0]       dest_q;
  logic [LEN_W-1:0]     rem_q;
  logic [1:0]           occ, occ_nxt;
  logic [A_W+D_W-1:0]   ent0_data, ent1_data;
  logic                 ent0_last, ent1_last;
  logic                 pl_rdy_q;
  logic                 err_q;
  logic [31:0]          pkt_cnt_q;

  logic req_hs, req_bad, push, pop, push_last;
  logic [A_W+D_W-1:0] new_flit;

  assign req_ready = (state == IDLE) & ~rst;
  assign pl_ready  = pl_rdy_q & ~rst;

  assign req_hs    = req_valid & req_ready;
  assign req_bad   = (req_len == '0) | (32'(req_len) > MAX_LEN_U) | (32'(req_dest) >= N_U);
  assign push      = pl_valid & pl_ready;
  assign pop       = m_axis_wvalid & m_axis_wready;
  assign push_last = (rem_q == LEN_W'(1));
  assign new_flit  = {dest_q, pl_data};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs && !req_bad) state_nxt = SEND;
      SEND:    if (push && push_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    occ_nxt = occ;
    if (push && !pop)      occ_nxt = occ + 2'd1;
    else if (!push && pop) occ_nxt = occ - 2'd1;
  end

  // Control and buffer head (head is reset so the output flit reads zero)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      occ       <= 2'd0;
      pl_rdy_q  <= 1'b0;
      err_q     <= 1'b0;
      pkt_cnt_q <= 32'd0;
      ent0_data <= '0;
      ent0_last <= 1'b0;
    end else begin
      state    <= state_nxt;
      occ      <= occ_nxt;
      // Ready is decided from next-cycle occupancy so it never depends on wready combinationally.
      pl_rdy_q <= (state_nxt == SEND) && (occ_nxt != 2'd2);
      err_q    <= req_hs & req_bad;
      if (pop && ent0_last) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      // Head takes the new beat when the buffer is empty or its only entry leaves;
      // otherwise a pop shifts the second entry forward.
      if (push && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        ent0_data <= new_flit;
        ent0_last <= push_last;
      end else if (pop && (occ == 2'd2)) begin
        ent0_data <= ent1_data;
        ent0_last <= ent1_last;
      end
    end
  end

  // Datapath registers: packet context and second buffer entry
  always_ff @(posedge clk) begin
    if (req_hs) begin
      dest_q <= req_dest;
      rem_q  <= req_len;
    end else if (push) begin
      rem_q  <= rem_q - LEN_W'(1);
    end
    if (push && (((occ == 2'd1) && !pop) || ((occ == 2'd2) && pop))) begin
      ent1_data <= new_flit;
      ent1_last <= push_last;
    end
  end

  assign m_axis_wvalid = (occ != 2'd0);
  assign m_axis_wlast  = ent0_last & m_axis_wvalid;
  assign m_axis_wdata  = ent0_data;
  assign busy          = (state == SEND) | (occ != 2'd0);
  assign err           = err_q;
  assign pkt_count     = pkt_cnt_q;

endmodule
